// File: rtl/bram_snap_ctrl_if.sv
// rtl/bram_snap_ctrl_if.sv - control, sample and BRAM write-port bundle for bram_snap_ctrl
interface bram_snap_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  arm;
    logic                  trig;
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic [ADDR_WIDTH:0]   len;
    logic                  bram_wr;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH:0]   cap_count;

    modport master (
        output arm, trig, din, din_valid, len,
        input  bram_wr, bram_addr, bram_data, busy, done, cap_count
    );

    modport slave (
        input  arm, trig, din, din_valid, len,
        output bram_wr, bram_addr, bram_data, busy, done, cap_count
    );
endinterface

// File: rtl/bram_snap_ctrl.sv
// rtl/bram_snap_ctrl.sv - trigger-driven snapshot writer for a dual-port BRAM write port (option: SNAP_VALID_GATE_EN)
module bram_snap_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    bram_snap_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   cap_q;
    logic [ADDR_WIDTH:0]   len_d;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  sample_ok;

`ifdef SNAP_VALID_GATE_EN
    assign sample_ok = bus.din_valid;
`else
    // din_valid does not gate samples in this build
    assign sample_ok = bus.din_valid | 1'b1;
`endif

    always_comb begin
        len_d = bus.len;
        if (bus.len == '0 || bus.len > DEPTH) begin
            len_d = DEPTH;
        end
    end

    // cap_q counts accepted samples, so it is also the address of the next sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cap_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.arm) begin
                        len_q   <= len_d;
                        cap_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (bus.trig && sample_ok) begin
                        wr_q    <= 1'b1;
                        addr_q  <= '0;
                        data_q  <= bus.din;
                        cap_q   <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (cap_q == len_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else if (sample_ok) begin
                        wr_q   <= 1'b1;
                        addr_q <= cap_q[ADDR_WIDTH-1:0];
                        data_q <= bus.din;
                        cap_q  <= cap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.bram_wr   = wr_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_data = data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cap_count = cap_q;
endmodule
